wb_ctrl: RTL and testbench

Write-back controller that owns the single write port of the processor's 32-entry register file. It accepts results from two producers: the single-cycle ALU path and the multi-cycle load/store unit. Load returns are buffered in a small FIFO and arbitrated against ALU results so the register file receives at most one write per cycle. It also keeps a per-register pending scoreboard so decode can stall on operands of outstanding loads.

---
 rtl/wb_ctrl.sv | 125 ++++++++++++
 tb/tb_wb_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ctrl.sv
// Write-back controller: arbitrates ALU results against buffered load returns
// onto the single register file write port and tracks loads still in flight.
module wb_ctrl #(
  parameter int W      = 32,
  parameter int nu_reg = 5,
  parameter int DEPTH  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alu_valid_i,
  input  logic [nu_reg-1:0]    alu_rd_i,
  input  logic [W-1:0]         alu_data_i,
  output logic                 alu_ready_o,
  input  logic                 lsu_valid_i,
  input  logic [nu_reg-1:0]    lsu_rd_i,
  input  logic [W-1:0]         lsu_data_i,
  output logic                 lsu_ready_o,
  input  logic                 issue_load_i,
  input  logic [nu_reg-1:0]    issue_rd_i,
  output logic [2**nu_reg-1:0] pending_o,
  output logic                 wr_en_d_o,
  output logic [nu_reg-1:0]    addr_d_o,
  output logic [W-1:0]         data_d_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int NR = 2**nu_reg;

  logic [nu_reg-1:0] r_fifoRd   [DEPTH];
  logic [W-1:0]      r_fifoData [DEPTH];
  logic [AW:0]       r_wrPtr;
  logic [AW:0]       r_rdPtr;
  logic [NR-1:0]     r_pending;
  logic              r_wrEn;
  logic [nu_reg-1:0] r_addr;
  logic [W-1:0]      r_data;

  logic [AW:0]       w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_useFifo;
  logic              w_useAlu;
  logic              w_sel;
  logic [AW-1:0]     w_wrIdx;
  logic [AW-1:0]     w_rdIdx;
  logic [nu_reg-1:0] w_selRd;
  logic [W-1:0]      w_selData;
  logic [NR-1:0]     w_pendNext;

  // Pointers carry one extra bit so a full FIFO is distinguishable from empty.
  assign w_count = r_wrPtr - r_rdPtr;
  assign w_full  = w_count[AW];
  assign w_empty = (w_count == '0);
  assign w_wrIdx = r_wrPtr[AW-1:0];
  assign w_rdIdx = r_rdPtr[AW-1:0];
  assign w_push  = lsu_valid_i && !w_full;

  assign alu_ready_o = !w_full;
  assign lsu_ready_o = !w_full;

  always_comb begin
    w_useFifo = 1'b0;
    w_useAlu  = 1'b0;
    if (w_full) begin
      w_useFifo = 1'b1;
    end else if (alu_valid_i) begin
      w_useAlu = 1'b1;
    end else if (!w_empty) begin
      w_useFifo = 1'b1;
    end
  end

  assign w_sel     = w_useFifo || w_useAlu;
  assign w_selRd   = w_useFifo ? r_fifoRd[w_rdIdx]   : alu_rd_i;
  assign w_selData = w_useFifo ? r_fifoData[w_rdIdx] : alu_data_i;

  // A new issue to the same register outranks the clear from its older pop.
  always_comb begin
    w_pendNext = r_pending;
    if (w_useFifo && (w_selRd != '0)) begin
      w_pendNext[w_selRd] = 1'b0;
    end
    if (issue_load_i) begin
      w_pendNext[issue_rd_i] = 1'b1;
    end
    w_pendNext[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifoRd[w_wrIdx]   <= lsu_rd_i;
      r_fifoData[w_wrIdx] <= lsu_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_pending <= '0;
      r_wrEn    <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_useFifo) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      r_pending <= w_pendNext;
      r_wrEn    <= w_sel && (w_selRd != '0);
      if (w_sel) begin
        r_addr <= w_selRd;
        r_data <= w_selData;
      end
    end
  end

  assign pending_o = r_pending;
  assign wr_en_d_o = r_wrEn;
  assign addr_d_o  = r_addr;
  assign data_d_o  = r_data;

endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl: queue-based reference model compared every
// cycle, plus directed sequences with hand-computed expectations.
module tb_wb_ctrl;
  localparam int W      = 32;
  localparam int NuReg  = 5;
  localparam int Depth  = 4;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        aluValid = 1'b0;
  logic [4:0]  aluRd = '0;
  logic [31:0] aluData = '0;
  logic        aluReady;
  logic        lsuValid = 1'b0;
  logic [4:0]  lsuRd = '0;
  logic [31:0] lsuData = '0;
  logic        lsuReady;
  logic        issueLoad = 1'b0;
  logic [4:0]  issueRd = '0;
  logic [31:0] pending;
  logic        wrEn;
  logic [4:0]  addr;
  logic [31:0] data;

  int checks = 0;
  int errors = 0;
  bit compareOn = 1'b0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entryT;

  entryT       mFifo[$];
  logic [31:0] mPending;
  logic        mWrEn;
  logic [4:0]  mAddr;
  logic [31:0] mData;

  always #5 clk = ~clk;

  wb_ctrl #(.W(W), .nu_reg(NuReg), .DEPTH(Depth)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .alu_valid_i  (aluValid),
    .alu_rd_i     (aluRd),
    .alu_data_i   (aluData),
    .alu_ready_o  (aluReady),
    .lsu_valid_i  (lsuValid),
    .lsu_rd_i     (lsuRd),
    .lsu_data_i   (lsuData),
    .lsu_ready_o  (lsuReady),
    .issue_load_i (issueLoad),
    .issue_rd_i   (issueRd),
    .pending_o    (pending),
    .wr_en_d_o    (wrEn),
    .addr_d_o     (addr),
    .data_d_o     (data)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mFifo.delete();
    mPending = '0;
    mWrEn    = 1'b0;
    mAddr    = '0;
    mData    = '0;
  endtask

  // One clock edge of the write-back rules: full FIFO drains first, then ALU, then FIFO.
  task automatic modelStep();
    entryT       e;
    bit          full;
    bit          any;
    logic [4:0]  rd;
    logic [31:0] d;
    full = (mFifo.size() == Depth);
    any  = 1'b1;
    rd   = '0;
    d    = '0;
    if (full || (!aluValid && mFifo.size() > 0)) begin
      e  = mFifo.pop_front();
      rd = e.rd;
      d  = e.data;
      if (rd != 0) mPending[rd] = 1'b0;
    end else if (aluValid) begin
      rd = aluRd;
      d  = aluData;
    end else begin
      any = 1'b0;
    end
    if (issueLoad && issueRd != 0) mPending[issueRd] = 1'b1;
    if (lsuValid && !full) mFifo.push_back('{rd: lsuRd, data: lsuData});
    mWrEn = any && (rd != 0);
    if (any) begin
      mAddr = rd;
      mData = d;
    end
  endtask

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) modelReset();
    else modelStep();
  end

  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("cmpWrEn", 64'(wrEn), 64'(mWrEn));
      checkOutput("cmpAddr", 64'(addr), 64'(mAddr));
      checkOutput("cmpData", 64'(data), 64'(mData));
      checkOutput("cmpPending", 64'(pending), 64'(mPending));
      checkOutput("cmpAluReady", 64'(aluReady), 64'(mFifo.size() != Depth));
      checkOutput("cmpLsuReady", 64'(lsuReady), 64'(mFifo.size() != Depth));
      checkOutput("x0Write", 64'(wrEn && (addr == 0)), 64'(0));
    end
  end

  // Drives one cycle of inputs, then returns just after the consuming edge.
  task automatic applyStimulus(input logic aV, input logic [4:0] aR, input logic [31:0] aD,
                               input logic lV, input logic [4:0] lR, input logic [31:0] lD,
                               input logic iV, input logic [4:0] iR);
    aluValid  = aV;
    aluRd     = aR;
    aluData   = aD;
    lsuValid  = lV;
    lsuRd     = lR;
    lsuData   = lD;
    issueLoad = iV;
    issueRd   = iR;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_ni    = 1'b1;
    compareOn = 1'b1;
    checkOutput("rstWrEn", 64'(wrEn), 0);
    checkOutput("rstAddr", 64'(addr), 0);
    checkOutput("rstData", 64'(data), 0);
    checkOutput("rstAluReady", 64'(aluReady), 1);
    checkOutput("rstLsuReady", 64'(lsuReady), 1);

    // Mid-cycle reset with a load buffered and a pending bit set
    applyStimulus(0, 0, 0, 1, 3, 32'h33, 1, 3);
    applyStimulus(1, 6, 32'h66, 0, 0, 0, 0, 0);
    checkOutput("preRstAddr", 64'(addr), 6);
    checkOutput("preRstPend", 64'(pending), 64'(32'h8));
    #2;
    rst_ni = 1'b0;
    aluValid = 1'b0;
    #1;
    checkOutput("midRstWrEn", 64'(wrEn), 0);
    checkOutput("midRstAddr", 64'(addr), 0);
    checkOutput("midRstData", 64'(data), 0);
    checkOutput("midRstPend", 64'(pending), 0);
    checkOutput("midRstAluReady", 64'(aluReady), 1);
    checkOutput("midRstLsuReady", 64'(lsuReady), 1);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    idle();
    checkOutput("rstDiscard", 64'(wrEn), 0);

    // Single ALU write
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    checkOutput("aluWrEn", 64'(wrEn), 1);
    checkOutput("aluAddr", 64'(addr), 5);
    checkOutput("aluData", 64'(data), 64'(32'hDEADBEEF));
    idle();
    checkOutput("aluWrEnOff", 64'(wrEn), 0);
    checkOutput("aluDataHold", 64'(data), 64'(32'hDEADBEEF));

    // x0 filtering on both paths
    checkOutput("x0AluReady", 64'(aluReady), 1);
    applyStimulus(1, 0, 32'h11, 0, 0, 0, 0, 0);
    checkOutput("x0AluWrEn", 64'(wrEn), 0);
    checkOutput("x0AluData", 64'(data), 64'(32'h11));
    applyStimulus(0, 0, 0, 1, 0, 32'h22, 0, 0);
    checkOutput("x0LsuWrEn1", 64'(wrEn), 0);
    idle();
    checkOutput("x0LsuWrEn2", 64'(wrEn), 0);
    checkOutput("x0LsuData", 64'(data), 64'(32'h22));
    idle();
    checkOutput("x0Empty", 64'(lsuReady), 1);

    // Load vs ALU priority with the FIFO filled to capacity
    for (int k = 1; k <= 4; k++) applyStimulus(1, 9, 32'h99, 1, 5'(k), 32'(256 + k), 0, 0);
    checkOutput("fullAluReady", 64'(aluReady), 0);
    checkOutput("fullLsuReady", 64'(lsuReady), 0);
    applyStimulus(1, 9, 32'h99, 0, 0, 0, 0, 0);
    checkOutput("forcePopAddr", 64'(addr), 1);
    checkOutput("forcePopData", 64'(data), 64'(32'h101));
    checkOutput("stallRelease", 64'(aluReady), 1);
    applyStimulus(1, 9, 32'h99, 0, 0, 0, 0, 0);
    checkOutput("aluAfterPop", 64'(addr), 9);
    for (int k = 2; k <= 4; k++) begin
      idle();
      checkOutput("drainAddr", 64'(addr), 64'(k));
      checkOutput("drainData", 64'(data), 64'(256 + k));
    end
    idle();
    checkOutput("drainDone", 64'(wrEn), 0);

    // Scoreboard set, hold, clear at pop, and same-cycle re-issue
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7);
    checkOutput("pendSet", 64'(pending[7]), 1);
    idle();
    idle();
    checkOutput("pendHold", 64'(pending[7]), 1);
    applyStimulus(0, 0, 0, 1, 7, 32'h77, 0, 0);
    checkOutput("pendQueued", 64'(pending[7]), 1);
    idle();
    checkOutput("pendClear", 64'(pending[7]), 0);
    checkOutput("pendClearWr", 64'(wrEn), 1);
    applyStimulus(0, 0, 0, 1, 7, 32'h78, 1, 7);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7);
    checkOutput("pendSetWins", 64'(pending[7]), 1);
    checkOutput("pendSetWinsWr", 64'(addr), 7);

    // Random stress with occasional mid-cycle resets
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if ($urandom_range(0, 599) == 0) begin
        #2;
        rst_ni   = 1'b0;
        aluValid = 1'b0;
        lsuValid = 1'b0;
        issueLoad = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
      end else begin
        applyStimulus($urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)), $urandom(),
                      $urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)), $urandom(),
                      $urandom_range(0, 99) < 30, 5'($urandom_range(0, 7)));
      end
    end
    repeat (8) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
